// File: rtl/issue_scoreboard.sv
// Issue scoreboard: gates decoded instructions into execute. Per-register
// pending-write counters detect RAW hazards and saturated destinations.
// Also keeps hazard-stall statistics and a sticky retirement-error flag.
module issue_scoreboard #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [4:0]             dec_rs1_i,
  input  logic [4:0]             dec_rs2_i,
  input  logic [4:0]             dec_rd_i,
  input  logic                   dec_use_rs1_i,
  input  logic                   dec_use_rs2_i,
  input  logic                   dec_we_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  input  logic                   wb_valid_i,
  input  logic [4:0]             wb_rd_i,
  output logic                   stall_o,
  output logic                   busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   sb_err_o
);

  localparam int unsigned AW = 5;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [STALL_CNT_W-1:0] StallMax = '1;

  logic [CNT_W-1:0]       pend_q [NUM_REGS];
  logic [CNT_W-1:0]       pend_d [NUM_REGS];
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   sb_err_q, sb_err_d;

  logic raw, waw_full, hazard, issue;

  // x0 and out-of-range addresses always read as "nothing pending".
  function automatic logic [CNT_W-1:0] pend_of(input logic [AW-1:0] addr);
    logic [CNT_W-1:0] val;
    val = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (addr == AW'(r)) val = pend_q[r];
    end
    return val;
  endfunction

  // Hazard detection and handshake, from registered counters only.
  always_comb begin
    raw      = (dec_use_rs1_i && (pend_of(dec_rs1_i) != '0)) ||
               (dec_use_rs2_i && (pend_of(dec_rs2_i) != '0));
    waw_full = dec_we_i && (dec_rd_i != '0) && (pend_of(dec_rd_i) == CntMax);
    hazard   = dec_valid_i && (raw || waw_full);
    ex_valid_o  = dec_valid_i && !hazard && !flush_i;
    dec_ready_o = ex_ready_i && !hazard && !flush_i;
    stall_o     = hazard && !flush_i;
    issue       = ex_valid_o && ex_ready_i;
  end

  // Next-state counters: issue increments, retirement decrements, flush clears.
  always_comb begin
    logic inc, dec;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      inc = issue && dec_we_i && (dec_rd_i == AW'(r)) && (r != 0);
      dec = wb_valid_i && (wb_rd_i == AW'(r)) && (r != 0) && (pend_q[r] != '0);
      if (inc && !dec) begin
        pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec && !inc) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end
      if (flush_i || (r == 0)) pend_d[r] = '0;
    end
  end

  // Statistics and sticky error next-state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != StallMax)) stall_cnt_d = stall_cnt_q + 1'b1;
    sb_err_d = sb_err_q;
    if (wb_valid_i && (wb_rd_i != '0) && (pend_of(wb_rd_i) == '0)) sb_err_d = 1'b1;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  // Busy view derived from registered counters.
  always_comb begin
    busy_o = 1'b0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (pend_q[r] != '0) busy_o = 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign sb_err_o    = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic        dec_use_rs1_i, dec_use_rs2_i, dec_we_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] stall_cnt_o;
  logic        sb_err_o;

  int vectors = 0;
  int miscompares = 0;

  issue_scoreboard #(
    .NUM_REGS(32),
    .CNT_W(2),
    .STALL_CNT_W(32)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .flush_i(flush_i),
    .dec_valid_i(dec_valid_i),
    .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i),
    .dec_rs2_i(dec_rs2_i),
    .dec_rd_i(dec_rd_i),
    .dec_use_rs1_i(dec_use_rs1_i),
    .dec_use_rs2_i(dec_use_rs2_i),
    .dec_we_i(dec_we_i),
    .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i),
    .wb_valid_i(wb_valid_i),
    .wb_rd_i(wb_rd_i),
    .stall_o(stall_o),
    .busy_o(busy_o),
    .stall_cnt_o(stall_cnt_o),
    .sb_err_o(sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic we);
    dec_valid_i = v; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
    dec_use_rs1_i = u1; dec_use_rs2_i = u2; dec_we_i = we;
  endtask

  // Advance one cycle; wb and flush are single-cycle pulses.
  task automatic nxt();
    @(posedge clk_i);
    #1;
    wb_valid_i = 1'b0;
    wb_rd_i    = '0;
    flush_i    = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_rd_i = '0;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_dec_ready", 32'(dec_ready_o), 1);
    chk("rst_ex_valid", 32'(ex_valid_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_sb_err", 32'(sb_err_o), 0);

    // addi x5, x0, imm
    nxt(); set_dec(1, 0, 0, 5, 1, 0, 1); #1;
    chk("addi_ex_valid", 32'(ex_valid_o), 1);
    chk("addi_dec_ready", 32'(dec_ready_o), 1);
    chk("addi_stall", 32'(stall_o), 0);

    // add x6, x5, x1 back-to-back: RAW stall for 3 cycles
    nxt(); set_dec(1, 5, 1, 6, 1, 1, 1); #1;
    chk("raw_busy", 32'(busy_o), 1);
    chk("raw_stall_c1", 32'(stall_o), 1);
    chk("raw_dec_ready_c1", 32'(dec_ready_o), 0);
    chk("raw_ex_valid_c1", 32'(ex_valid_o), 0);
    nxt(); #1;
    chk("raw_stall_c2", 32'(stall_o), 1);
    nxt(); wb(5); #1;
    chk("raw_stall_c3_no_bypass", 32'(stall_o), 1);
    nxt(); #1;
    chk("raw_issue_c4", 32'(ex_valid_o), 1);
    chk("raw_stall_c4", 32'(stall_o), 0);
    chk("raw_stall_cnt", stall_cnt_o, 3);
    nxt(); set_dec(0, 0, 0, 0, 0, 0, 0); wb(6); #1;

    // Immediate form ignores rs2
    nxt(); set_dec(1, 0, 0, 7, 0, 0, 1); #1;
    chk("imm_busy_clear", 32'(busy_o), 0);
    chk("imm_writer_issue", 32'(ex_valid_o), 1);
    nxt(); set_dec(1, 0, 7, 0, 1, 0, 0); #1;
    chk("imm_no_stall", 32'(stall_o), 0);
    chk("imm_issue", 32'(ex_valid_o), 1);
    nxt(); set_dec(0, 0, 0, 0, 0, 0, 0); wb(7); #1;

    // Writes to x0 are never tracked
    nxt(); set_dec(1, 0, 0, 0, 0, 0, 1); #1;
    chk("x0_writer_issue", 32'(ex_valid_o), 1);
    nxt(); set_dec(1, 0, 0, 3, 1, 1, 0); #1;
    chk("x0_busy", 32'(busy_o), 0);
    chk("x0_reader_stall", 32'(stall_o), 0);

    // Back-pressure is not a hazard and is not counted
    nxt(); ex_ready_i = 1'b0; set_dec(1, 0, 0, 0, 0, 0, 0); #1;
    chk("bp_dec_ready", 32'(dec_ready_o), 0);
    chk("bp_ex_valid", 32'(ex_valid_o), 1);
    chk("bp_stall", 32'(stall_o), 0);
    nxt(); ex_ready_i = 1'b1; #1;
    chk("bp_stall_cnt", stall_cnt_o, 3);

    // Saturation of x9 at 3 pending writes
    nxt(); set_dec(1, 0, 0, 9, 0, 0, 1); #1;
    nxt(); #1;
    nxt(); #1;
    chk("sat_third_issue", 32'(ex_valid_o), 1);
    nxt(); #1;
    chk("sat_stall", 32'(stall_o), 1);
    nxt(); wb(9); #1;
    chk("sat_stall_during_wb", 32'(stall_o), 1);
    nxt(); #1;
    chk("sat_issue_after_wb", 32'(ex_valid_o), 1);
    chk("sat_stall_cnt", stall_cnt_o, 5);
    nxt(); #1;
    chk("sat_full_again", 32'(stall_o), 1);
    nxt(); set_dec(0, 0, 0, 0, 0, 0, 0); wb(9); #1;
    nxt(); wb(9); #1;
    nxt(); wb(9); #1;
    nxt(); #1;
    chk("sat_drained", 32'(busy_o), 0);
    chk("sat_stall_cnt2", stall_cnt_o, 6);
    chk("sat_no_err", 32'(sb_err_o), 0);

    // Simultaneous issue and retirement of x4
    nxt(); set_dec(1, 0, 0, 4, 0, 0, 1); #1;
    chk("sim_first_issue", 32'(ex_valid_o), 1);
    nxt(); wb(4); #1;
    chk("sim_issue_with_wb", 32'(ex_valid_o), 1);
    nxt(); set_dec(1, 4, 0, 0, 1, 0, 0); wb(4); #1;
    chk("sim_pend_still_1", 32'(stall_o), 1);
    nxt(); #1;
    chk("sim_busy_clear", 32'(busy_o), 0);
    chk("sim_reader_issue", 32'(ex_valid_o), 1);
    chk("sim_stall_cnt", stall_cnt_o, 7);

    // Spurious retirement sets sticky error
    nxt(); set_dec(0, 0, 0, 0, 0, 0, 0); wb(12); #1;
    chk("err_before_edge", 32'(sb_err_o), 0);
    nxt(); #1;
    chk("err_set", 32'(sb_err_o), 1);
    chk("err_no_pend", 32'(busy_o), 0);
    nxt(); #1;
    chk("err_sticky", 32'(sb_err_o), 1);

    // Flush clears counters and blocks issue
    nxt(); set_dec(1, 0, 0, 3, 0, 0, 1); #1;
    nxt(); #1;
    nxt(); set_dec(1, 0, 0, 8, 0, 0, 1); #1;
    nxt(); set_dec(1, 0, 0, 10, 0, 0, 1); flush_i = 1'b1; #1;
    chk("flush_ex_valid", 32'(ex_valid_o), 0);
    chk("flush_dec_ready", 32'(dec_ready_o), 0);
    chk("flush_stall", 32'(stall_o), 0);
    chk("flush_busy_before", 32'(busy_o), 1);
    nxt(); set_dec(1, 3, 0, 0, 1, 0, 0); #1;
    chk("flush_busy_after", 32'(busy_o), 0);
    chk("flush_reader_stall", 32'(stall_o), 0);
    chk("flush_reader_issue", 32'(ex_valid_o), 1);
    chk("flush_stall_cnt_kept", stall_cnt_o, 7);
    chk("flush_err_kept", 32'(sb_err_o), 1);

    // Asynchronous reset mid-stall
    nxt(); set_dec(1, 0, 0, 5, 0, 0, 1); #1;
    nxt(); set_dec(1, 5, 0, 0, 1, 0, 0); #1;
    chk("arst_pre_stall", 32'(stall_o), 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_o), 0);
    chk("arst_dec_ready", 32'(dec_ready_o), 1);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_stall_cnt", stall_cnt_o, 0);
    chk("arst_err", 32'(sb_err_o), 0);
    nxt(); rstn_i = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

- Sits between the decoder and the execute stage.
- Gates each decoded instruction into execute.
- Tracks in-flight register writes in a per-register pending counter and holds decode while an instruction reads a register with an outstanding write (RAW).
- Also holds decode when the destination counter is saturated, plus on back-pressure and flush.
- Writeback retirements release registers.
- Reports stall statistics and a sticky bookkeeping-error flag.

## Interface

Parameters:
- NUM_REGS, 32, architectural integer registers; x0 never tracked
- CNT_W, 2, per-register pending counter width; max pending writes per register = 2^CNT_W-1
- STALL_CNT_W, 32, width of hazard-stall statistics counter

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; clears scoreboard, blocks issue this cycle
- dec_valid_i  in  1  decoded instruction present
- dec_ready_o  out  1  instruction accepted this cycle
- dec_rs1_i  in  5  source register 1 address
- dec_rs2_i  in  5  source register 2 address
- dec_rd_i  in  5  destination address
- dec_use_rs1_i  in  1  instruction reads rs1
- dec_use_rs2_i  in  1  instruction reads rs2 (0 for immediate forms)
- dec_we_i  in  1  instruction writes rd
- ex_valid_o  out  1  instruction issued to execute
- ex_ready_i  in  1  execute can accept
- wb_valid_i  in  1  a register write retires this cycle
- wb_rd_i  in  5  retiring destination
- stall_o  out  1  decode held due to hazard (not back-pressure)
- busy_o  out  1  any register has pending>0 (registered view)
- stall_cnt_o  out  STALL_CNT_W  saturating hazard-stall cycle count
- sb_err_o  out  1  sticky: retirement to a register with pending==0

## Operation

- State: pend[1..NUM_REGS-1] (CNT_W bits each), stall_cnt, sb_err. Reset: all zero. Consequently the outputs after reset are dec_ready_o=ex_ready_i, ex_valid_o=dec_valid_i, stall_o=0, busy_o=0, stall_cnt_o=0, sb_err_o=0.
- raw = (use_rs1 && rs1!=0 && pend[rs1]!=0) || (use_rs2 && rs2!=0 && pend[rs2]!=0).
- waw_full = we && rd!=0 && pend[rd]==max.
- hazard = dec_valid_i && (raw || waw_full).
- Hazard uses registered pend only. There is no same-cycle writeback bypass.
- Combinational outputs:
  - ex_valid_o = dec_valid_i && !hazard && !flush_i.
  - dec_ready_o = ex_ready_i && !hazard && !flush_i.
  - stall_o = hazard && !flush_i.
- issue = ex_valid_o && ex_ready_i. Handshake is valid/ready; the upstream must hold its fields stable while dec_valid_i && !dec_ready_o.
- Counter update per register r≠0, evaluated each cycle:
  - inc = issue && dec_we_i && dec_rd_i==r.
  - dec = wb_valid_i && wb_rd_i==r && pend[r]!=0.
  - inc&&dec: unchanged. inc only: +1. dec only: −1.
- Writes to x0 (issue or writeback) are ignored.
- wb_valid_i with pend[wb_rd_i]==0 and wb_rd_i!=0: no counter change; sb_err set. sb_err clears only on reset.
- Flush: all pend cleared to 0 next edge. Issue and writeback updates in the flush cycle are discarded. sb_err and stall_cnt are unaffected.
- stall_cnt increments when stall_o=1 and saturates at all-ones. Back-pressure cycles (ex_ready_i=0 without hazard) are not counted.
- busy_o = OR of all pend!=0, from registered state.

## Timing

- Issue latency 0: an instruction with no hazard and ex_ready_i=1 passes in the same cycle.
- A retirement at edge N makes a dependent instruction issuable in cycle N+1. Minimum RAW bubble is one cycle beyond writeback.
- Issue of rd at edge N makes pend[rd] visible from cycle N+1. A back-to-back dependent instruction stalls.
- Asynchronous reset mid-stall drops the stall immediately. pend is zeroed without waiting for a clock.
- Flush and dec_valid_i in the same cycle: no issue, dec_ready_o=0. The upstream flush discards the instruction.

## Test plan

- Reset: rstn_i=0 then release with dec_valid_i=0 -> busy_o=0, stall_cnt_o=0, sb_err_o=0. Then addi x5 (we=1, rd=5, use_rs1 rs1=0) with ex_ready_i=1 -> ex_valid_o=1 same cycle, busy_o=1 next cycle.
- RAW stall: issue rd=5. Next cycle add x6,x5,x1 -> stall_o=1, dec_ready_o=0 for 3 cycles. wb_rd_i=5 at cycle 3 -> issue at cycle 4, stall_cnt_o=3.
- Immediate form: pend[7]=1, instruction rs2=7 with use_rs2=0 -> no stall. Source x0 with pend[0] never set -> no stall.
- Saturation: three issues to rd=9 with CNT_W=2 (pend=3). A fourth writer of rd=9 -> stall_o=1 until one writeback of 9, then issue; pend stays 3.
- Simultaneous: pend[4]=1, issue rd=4 and wb_rd_i=4 in the same cycle -> pend[4]=1 after the edge. A spurious wb_rd_i=12 with pend 0 -> sb_err_o=1 persists.
- Flush: pend[3]=2, pend[8]=1, flush_i=1 with dec_valid_i=1 -> ex_valid_o=0. Next cycle busy_o=0, and a reader of x3 issues without stall.
